// File: rtl/d_latch_pkg.sv
// ============================================================================
// Module      : d_latch_pkg
// Description : Shared constants and update-priority decode for d_latch_reset_n.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package d_latch_pkg;

  localparam int   c_default_width     = 1;
  localparam logic c_default_reset_bit = 1'b0;

  // Update source selected at a clock edge, highest priority first.
  typedef enum logic [1:0] {
    RST  = 2'd0,
    CLR  = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } prio_e;

  function automatic prio_e decode_prio(input logic reset,
                                        input logic reset_n,
                                        input logic enable);
    if (reset)         return RST;
    else if (!reset_n) return CLR;
    else if (enable)   return LOAD;
    else               return HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/d_latch_reset_n_cell.sv
// ============================================================================
// Module      : d_latch_reset_n_cell
// Description : One storage bit with reset, clear, enable and optional
//               transparency (macro D_LATCH_RESET_N_TRANSPARENT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_latch_reset_n_cell
  import d_latch_pkg::*;
#(
  parameter logic RESET_BIT = c_default_reset_bit
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic enable,
  input  logic reset_n,
  output logic q,
  output logic q_changed
);

  prio_e w_sel;
  logic  w_next;
  logic  r_q;
  logic  r_changed;

  assign w_sel = decode_prio(reset, reset_n, enable);

  always_comb begin
    w_next = r_q;
    case (w_sel)
      RST, CLR: w_next = RESET_BIT;
      LOAD:     w_next = d;
      default:  w_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= RESET_BIT;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_next;
      r_changed <= (w_next != r_q);
    end
  end

  assign q_changed = r_changed;

`ifdef D_LATCH_RESET_N_TRANSPARENT_EN
  // Open latch: D passes straight through while a load is selected.
  assign q = (w_sel == LOAD) ? d : r_q;
`else
  assign q = r_q;
`endif

endmodule

`default_nettype wire

// File: rtl/d_latch_reset_n.sv
// ============================================================================
// Module      : d_latch_reset_n
// Description : WIDTH-bit enabled storage with synchronous reset/clear, change
//               pulse; D_LATCH_RESET_N_TRANSPARENT_EN makes it transparent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_latch_reset_n
  import d_latch_pkg::*;
#(
  parameter int               WIDTH       = c_default_width,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{c_default_reset_bit}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             enable,
  input  logic             reset_n,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q,
  output logic             q_changed
);

  logic [WIDTH-1:0] w_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_reset_n_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .d         (D[i]),
      .enable    (enable),
      .reset_n   (reset_n),
      .q         (Q[i]),
      .q_changed (w_changed[i])
    );
  end

  assign not_Q     = ~Q;
  assign q_changed = |w_changed;

endmodule

`default_nettype wire

// File: tb/tb_d_latch_reset_n.sv
// ============================================================================
// Module      : tb_d_latch_reset_n
// Description : Directed-vector bench for d_latch_reset_n at WIDTH=1 and 8;
//               honours D_LATCH_RESET_N_TRANSPARENT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_latch_reset_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       d1, en1, rn1;
  logic       q1, nq1, qc1;
  logic [7:0] d8, q8, nq8;
  logic       en8, rn8, qc8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_latch_reset_n #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .D(d1), .enable(en1), .reset_n(rn1),
    .Q(q1), .not_Q(nq1), .q_changed(qc1)
  );

  d_latch_reset_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .D(d8), .enable(en8), .reset_n(rn8),
    .Q(q8), .not_Q(nq8), .q_changed(qc8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d1 = 1'b1; en1 = 1'b1; rn1 = 1'b1;
    d8 = 8'hFF; en8 = 1'b1; rn8 = 1'b1;
    tick();
    tick();
    check("rst_q1",   {7'd0, q1},  8'h00);
    check("rst_nq1",  {7'd0, nq1}, 8'h01);
    check("rst_qc1",  {7'd0, qc1}, 8'h00);
    check("rst_q8",   q8,          8'h00);
    check("rst_nq8",  nq8,         8'hFF);
    check("rst_qc8",  {7'd0, qc8}, 8'h00);

    // Load 1 then 0 on successive edges.
    reset = 1'b0; en8 = 1'b0; d1 = 1'b1;
    tick();
    check("load1_q",  {7'd0, q1},  8'h01);
    check("load1_nq", {7'd0, nq1}, 8'h00);
    check("load1_qc", {7'd0, qc1}, 8'h01);
    d1 = 1'b0;
    tick();
    check("load0_q",  {7'd0, q1},  8'h00);
    check("load0_nq", {7'd0, nq1}, 8'h01);
    check("load0_qc", {7'd0, qc1}, 8'h01);

    // Hold: D toggles with enable low.
    en1 = 1'b0; d1 = 1'b1;
    tick();
    check("hold1_q",  {7'd0, q1},  8'h00);
    check("hold1_qc", {7'd0, qc1}, 8'h00);
    d1 = 1'b0;
    tick();
    check("hold0_q",  {7'd0, q1},  8'h00);
    check("hold0_qc", {7'd0, qc1}, 8'h00);

    // Mid-cycle D change with enable high.
    en1 = 1'b1; d1 = 1'b0;
    #2;
    d1 = 1'b1;
    #1;
`ifdef D_LATCH_RESET_N_TRANSPARENT_EN
    check("mid_q_transp", {7'd0, q1},  8'h01);
    check("mid_nq_transp", {7'd0, nq1}, 8'h00);
`else
    check("mid_q_reg",    {7'd0, q1},  8'h00);
    check("mid_nq_reg",   {7'd0, nq1}, 8'h01);
`endif
    check("mid_qc",       {7'd0, qc1}, 8'h00);
    tick();
    check("mid_edge_q",   {7'd0, q1},  8'h01);
    check("mid_edge_qc",  {7'd0, qc1}, 8'h01);

    // Clear beats enable.
    rn1 = 1'b0;
    tick();
    check("clr_q",   {7'd0, q1},  8'h00);
    check("clr_nq",  {7'd0, nq1}, 8'h01);
    check("clr_qc",  {7'd0, qc1}, 8'h01);
    tick();
    check("clr_same_qc", {7'd0, qc1}, 8'h00);

    // System reset beats everything and never pulses q_changed.
    rn1 = 1'b1;
    tick();
    check("pre_rst_q",  {7'd0, q1},  8'h01);
    reset = 1'b1;
    tick();
    check("sys_rst_q",  {7'd0, q1},  8'h00);
    check("sys_rst_qc", {7'd0, qc1}, 8'h00);
    reset = 1'b0;
    tick();
    check("post_rst_q",  {7'd0, q1},  8'h01);
    check("post_rst_qc", {7'd0, qc1}, 8'h01);

    // Enable low: hold even with D changing mid-cycle or unknown.
    en1 = 1'b0; d1 = 1'b0;
    #1;
    check("hold_mid_q", {7'd0, q1}, 8'h01);
    d1 = 1'bx;
    tick();
    check("hold_x_q",  {7'd0, q1},  8'h01);
    check("hold_x_nq", {7'd0, nq1}, 8'h00);
    check("hold_x_qc", {7'd0, qc1}, 8'h00);
    d1 = 1'b0;

    // WIDTH=8 load, reload of equal value, change, clear.
    en8 = 1'b1; d8 = 8'hA5;
    tick();
    check("w8_load_q",   q8,          8'hA5);
    check("w8_load_nq",  nq8,         8'h5A);
    check("w8_load_qc",  {7'd0, qc8}, 8'h01);
    tick();
    check("w8_reload_q",  q8,          8'hA5);
    check("w8_reload_qc", {7'd0, qc8}, 8'h00);
    d8 = 8'h5A;
    tick();
    check("w8_chg_q",    q8,          8'h5A);
    check("w8_chg_qc",   {7'd0, qc8}, 8'h01);
    rn8 = 1'b0;
    tick();
    check("w8_clr_q",    q8,          8'h00);
    check("w8_clr_nq",   nq8,         8'hFF);
    check("w8_clr_qc",   {7'd0, qc8}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
